// File: rtl/branch_history_table.sv
// branch_history_table
//   Table of ENTRIES 2-bit saturating counters indexed by word-aligned PC.
//   Fetch looks up a registered taken/not-taken prediction one cycle after
//   asking. Execute trains the counters with resolved outcomes. Resolved
//   mispredictions are counted with saturation. A clr pulse starts a walk
//   that rewrites every counter to weakly not-taken, one entry per cycle.
// Ports
//   clk, rst_n                   clock, async active-low reset
//   lookup_valid, lookup_pc      prediction request from fetch
//   pred_valid, pred_taken       registered prediction (one cycle later)
//   upd_valid, upd_pc,
//   upd_taken, upd_mispred       resolved branch from execute
//   clr                          start table clear (single-cycle pulse)
//   busy                         clear walk in progress
//   mispred_cnt                  saturating mispredict count
module branch_history_table #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  input  logic             clr,
  output logic             busy,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [1:0]       ctr [ENTRIES];
  logic             clr_wr;

  logic             lk_acc, up_acc;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [1:0]       up_ctr, lk_ctr;
  logic             vld_p1, taken_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Counter training: step toward the outcome, pinned at 0 and 3.
  function automatic logic [1:0] ctr_train(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];

  // Both ports are closed while the clear walk owns the table.
  assign lk_acc = lookup_valid & (state == IDLE);
  assign up_acc = upd_valid    & (state == IDLE);

  assign up_ctr = ctr_train(ctr[up_idx], upd_taken);
  // Write-first bypass: a same-cycle update to the looked-up entry is visible.
  assign lk_ctr = (up_acc && (up_idx == lk_idx)) ? up_ctr : ctr[lk_idx];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; clr during CLEAR is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (ptr == IDX_W'(ENTRIES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy is a decode of the state register only
  always_comb begin
    clr_wr = (state == CLEAR);
    busy   = clr_wr;
  end

  // Walk pointer sits at 0 in IDLE so every walk starts at entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= '0;
    else if (clr_wr) ptr <= ptr + IDX_W'(1);
    else             ptr <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (clr_wr) begin
      ctr[ptr] <= 2'b01;
    end else if (up_acc) begin
      ctr[up_idx] <= up_ctr;
    end
  end

  // ---- stage p1: registered prediction and mispredict count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      vld_p1   <= lk_acc;
      taken_p1 <= lk_acc & lk_ctr[1];
      if (upd_valid && upd_mispred) cnt_p1 <= cnt_sat_inc(cnt_p1);
    end
  end

  assign pred_valid  = vld_p1;
  assign pred_taken  = taken_p1;
  assign mispred_cnt = cnt_p1;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

endmodule
